// File: rtl/fsmd_result_reader.sv
// Collects result bytes from an FSMD over a Show_DATA/NEW_OUTPUT handshake into a FIFO
// and keeps per-run count, checksum and completion/timeout status.
module fsmd_result_reader #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  OUT,
  input  logic        NEW_OUTPUT,
  input  logic        Done_Flag,
  output logic        Show_DATA,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic [4:0]  level,
  output logic [7:0]  total,
  output logic [15:0] sum,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RELEASE, S_FINISH, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      total_q, total_d;
  logic [15:0]     sum_q, sum_d;
  logic            done_q, done_d, err_q, err_d;

  logic is_empty, is_full, capture, pop, start_ok, finish_hit, timed_out;

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CW'(DEPTH));
  assign capture    = (state_q == S_WAIT) && NEW_OUTPUT;
  assign finish_hit = (state_q == S_WAIT) && !NEW_OUTPUT && Done_Flag;
  assign timed_out  = (state_q == S_WAIT) && !NEW_OUTPUT && !Done_Flag &&
                      (timer_q == TW'(TIMEOUT - 1));
  assign pop        = rd_en && !is_empty;
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_ERR));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_REQ;
      S_REQ:     if (!is_full) state_d = S_WAIT;
      S_WAIT: begin
        if (capture)         state_d = S_RELEASE;
        else if (finish_hit) state_d = S_FINISH;
        else if (timed_out)  state_d = S_ERR;
      end
      S_RELEASE: if (!NEW_OUTPUT) state_d = S_REQ;
      S_FINISH:  state_d = S_IDLE;
      S_ERR:     if (start_ok) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request is only raised (driven low) when a slot is free, so a capture can never overflow.
  always_comb begin
    Show_DATA = !((state_q == S_WAIT) || ((state_q == S_REQ) && !is_full));
    busy      = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_RELEASE);
  end

  always_comb begin
    timer_d  = timer_q;
    total_d  = total_q;
    sum_d    = sum_q;
    done_d   = done_q;
    err_d    = err_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (state_q == S_REQ)  timer_d = '0;
    if (state_q == S_WAIT) timer_d = timer_q + TW'(1);

    if (start_ok) begin
      total_d = '0;
      sum_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    if (finish_hit) done_d = 1'b1;
    if (timed_out)  err_d  = 1'b1;

    if (capture) begin
      mem_d[wr_ptr_q] = OUT;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      total_d         = total_q + 8'd1;
      sum_d           = sum_q + {8'h00, OUT};
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (capture && !pop)      count_d = count_q + CW'(1);
    else if (!capture && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer_q  <= '0;
      total_q  <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      timer_q  <= timer_d;
      total_q  <= total_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data = is_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign empty   = is_empty;
  assign full    = is_full;
  assign level   = 5'(count_q);
  assign total   = total_q;
  assign sum     = sum_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fsmd_result_reader.sv
// Bench for fsmd_result_reader: a randomized FSMD responder drives the handshake while a
// queue-based model of the collection run predicts every output on every cycle.
module tb_fsmd_result_reader;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        start = 1'b0, NEW_OUTPUT = 1'b0, Done_Flag = 1'b0, rd_en = 1'b0;
  logic [7:0]  OUT = 8'h00;
  logic        Show_DATA, empty, full, busy, done, err;
  logic [7:0]  rd_data, total;
  logic [4:0]  level;
  logic [15:0] sum;

  int errors = 0;
  int checks = 0;
  bit chkEn  = 1'b0;

  fsmd_result_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .OUT(OUT), .NEW_OUTPUT(NEW_OUTPUT),
    .Done_Flag(Done_Flag), .Show_DATA(Show_DATA), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .level(level), .total(total), .sum(sum),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Model: the run phase named as in the description, the buffer as a queue, totals as plain sums
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_RELEASE = 3, P_FINISH = 4, P_ERR = 5;
  int         mPhase;
  logic [7:0] mQ[$];
  logic [7:0] mTotal;
  logic [15:0] mSum;
  bit         mDone, mErr;
  int         mWait;

  function automatic void modelReset();
    mPhase = P_IDLE; mQ.delete(); mTotal = 0; mSum = 0; mDone = 0; mErr = 0; mWait = 0;
  endfunction

  function automatic void modelClearRun();
    mTotal = 0; mSum = 0; mDone = 0; mErr = 0;
  endfunction

  function automatic void modelStep();
    bit doPop, doCap;
    int nxt;
    doPop = rd_en && (mQ.size() > 0);
    doCap = (mPhase == P_WAIT) && NEW_OUTPUT;
    nxt   = mPhase;
    case (mPhase)
      P_IDLE:    if (start) begin nxt = P_REQ; modelClearRun(); end
      P_REQ:     if (mQ.size() < DEPTH) begin nxt = P_WAIT; mWait = 0; end
      P_WAIT: begin
        if (NEW_OUTPUT) begin
          nxt = P_RELEASE; mTotal = mTotal + 8'd1; mSum = mSum + 16'(OUT);
        end else if (Done_Flag) begin
          nxt = P_FINISH; mDone = 1;
        end else begin
          mWait++;
          if (mWait == TIMEOUT) begin nxt = P_ERR; mErr = 1; end
        end
      end
      P_RELEASE: if (!NEW_OUTPUT) nxt = P_REQ;
      P_FINISH:  nxt = P_IDLE;
      P_ERR:     if (start) begin nxt = P_REQ; modelClearRun(); end
      default:   nxt = P_IDLE;
    endcase
    if (doPop) void'(mQ.pop_front());
    if (doCap) mQ.push_back(OUT);
    mPhase = nxt;
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) modelReset();
      else      modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chkEn) begin
      checkOutput("Show_DATA", 16'(Show_DATA),
                  16'(!((mPhase == P_WAIT) || ((mPhase == P_REQ) && (mQ.size() < DEPTH)))));
      checkOutput("busy", 16'(busy),
                  16'((mPhase == P_REQ) || (mPhase == P_WAIT) || (mPhase == P_RELEASE)));
      checkOutput("level", 16'(level), 16'(mQ.size()));
      checkOutput("empty", 16'(empty), 16'(mQ.size() == 0));
      checkOutput("full", 16'(full), 16'(mQ.size() == DEPTH));
      checkOutput("rd_data", 16'(rd_data), (mQ.size() > 0) ? 16'(mQ[0]) : 16'h0000);
      checkOutput("total", 16'(total), 16'(mTotal));
      checkOutput("sum", sum, mSum);
      checkOutput("done", 16'(done), 16'(mDone));
      checkOutput("err", 16'(err), 16'(mErr));
    end
  end

  logic [7:0] supplyQ[$];
  int remaining = 0;
  int holdLeft  = 0;
  int holdMin   = 2;
  int holdMax   = 4;

  task automatic applyStimulus(input bit st, input bit rd);
    start = st; rd_en = rd; NEW_OUTPUT = 1'b0; holdLeft = 0;
    @(negedge CLK);
    start = 1'b0; rd_en = 1'b0;
  endtask

  // FSMD stand-in: answers a low Show_DATA after a random delay, holds the strobe 2+ cycles
  task automatic runFsmd(input int rdPct, input int cycles, input bit untilIdle, input int stopLevel);
    bit reached;
    reached = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (untilIdle && ((mPhase == P_IDLE && mDone) || mPhase == P_ERR)) begin reached = 1; break; end
      if (stopLevel >= 0 && mPhase == P_WAIT && mQ.size() == stopLevel) begin reached = 1; break; end
      start = 1'b0;
      rd_en = ($urandom_range(0, 99) < rdPct);
      if (holdLeft > 0) begin
        NEW_OUTPUT = 1'b1;
        holdLeft--;
      end else begin
        NEW_OUTPUT = 1'b0;
        if (Show_DATA == 1'b0) begin
          if (remaining > 0) begin
            if ($urandom_range(0, 3) != 0) begin
              NEW_OUTPUT = 1'b1;
              OUT = (supplyQ.size() > 0) ? supplyQ.pop_front() : 8'($urandom);
              holdLeft = $urandom_range(holdMin, holdMax) - 1;
              remaining--;
              if (remaining == 0 && $urandom_range(0, 1) == 1) Done_Flag = 1'b1;
            end
          end else begin
            Done_Flag = 1'b1;
          end
        end
      end
      @(negedge CLK);
    end
    if ((untilIdle || stopLevel >= 0) && !reached) begin
      checks++; errors++;
      $display("[TB] FAIL run_budget: got no completion expected completion within %0d cycles", cycles);
    end
    rd_en = 1'b0;
    if (untilIdle) begin NEW_OUTPUT = 1'b0; Done_Flag = 1'b0; holdLeft = 0; end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_Show_DATA", 16'(Show_DATA), 16'h1);
    checkOutput("rst_empty", 16'(empty), 16'h1);
    checkOutput("rst_full", 16'(full), 16'h0);
    checkOutput("rst_level", 16'(level), 16'h0);
    checkOutput("rst_total", 16'(total), 16'h0);
    checkOutput("rst_sum", sum, 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_err", 16'(err), 16'h0);
    checkOutput("rst_rd_data", 16'(rd_data), 16'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expPop [3];
    expPop = '{8'h05, 8'h0A, 8'h0F};

    repeat (3) @(negedge CLK);
    chkEn = 1'b1;
    checkResetValues();
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] three-result run");
    supplyQ = '{8'h05, 8'h0A, 8'h0F};
    remaining = 3;
    applyStimulus(1, 0);
    runFsmd(0, 200, 1, -1);
    checkOutput("run3_total", 16'(total), 16'h0003);
    checkOutput("run3_sum", sum, 16'h001E);
    checkOutput("run3_done", 16'(done), 16'h1);
    checkOutput("model_sum", mSum, 16'h001E);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fifo_order", 16'(rd_data), 16'(expPop[i]));
      applyStimulus(0, 1);
    end
    checkOutput("drained_empty", 16'(empty), 16'h1);
    applyStimulus(0, 1);
    checkOutput("pop_empty_level", 16'(level), 16'h0);

    $display("[TB] long strobe");
    holdMin = 5; holdMax = 5; remaining = 1;
    applyStimulus(1, 0);
    runFsmd(0, 200, 1, -1);
    checkOutput("long_strobe_total", 16'(total), 16'h0001);
    checkOutput("long_strobe_level", 16'(level), 16'h0001);
    holdMin = 2; holdMax = 4;
    applyStimulus(0, 1);

    $display("[TB] fill to full");
    remaining = 10;
    applyStimulus(1, 0);
    runFsmd(0, 150, 0, -1);
    checkOutput("fill_full", 16'(full), 16'h1);
    checkOutput("fill_show", 16'(Show_DATA), 16'h1);
    checkOutput("fill_total", 16'(total), 16'h0008);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    runFsmd(0, 60, 0, -1);
    checkOutput("refill_level", 16'(level), 16'h0008);
    checkOutput("refill_total", 16'(total), 16'h000A);
    runFsmd(50, 400, 1, -1);
    checkOutput("fill_done", 16'(done), 16'h1);

    $display("[TB] timeout");
    applyStimulus(1, 0);
    repeat (TIMEOUT + 5) applyStimulus(0, 0);
    checkOutput("timeout_err", 16'(err), 16'h1);
    checkOutput("timeout_busy", 16'(busy), 16'h0);
    checkOutput("timeout_show", 16'(Show_DATA), 16'h1);
    applyStimulus(1, 0);
    checkOutput("restart_err", 16'(err), 16'h0);
    checkOutput("restart_show", 16'(Show_DATA), 16'h0);
    remaining = 4;
    runFsmd(30, 400, 1, -1);

    $display("[TB] randomized runs");
    holdMin = 2; holdMax = 6; remaining = 60;
    applyStimulus(1, 0);
    runFsmd(50, 3000, 1, -1);
    checkOutput("rand_total", 16'(total), 16'd60);
    remaining = 30;
    applyStimulus(1, 0);
    runFsmd(20, 3000, 1, -1);
    checkOutput("rand2_total", 16'(total), 16'd30);

    $display("[TB] reset mid-run");
    for (int i = 0; i < 20 && empty !== 1'b1; i++) applyStimulus(0, 1);
    holdMin = 2; holdMax = 3; remaining = 10;
    applyStimulus(1, 0);
    runFsmd(0, 200, 0, 4);
    checkOutput("pre_reset_level", 16'(level), 16'h0004);
    #2;
    RST = 1'b0;
    #1;
    checkResetValues();
    NEW_OUTPUT = 1'b0; Done_Flag = 1'b0; holdLeft = 0; remaining = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("post_reset_show", 16'(Show_DATA), 16'h1);
    checkOutput("post_reset_busy", 16'(busy), 16'h0);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
